// File: rtl/conv_pkg.sv
// Shared sizes, FSM state type and pixel/weight index helpers for the 3x3 convolution engine.
package conv_pkg;

  localparam int IMG_DIM  = 6;
  localparam int K_DIM    = 3;
  localparam int OUT_DIM  = IMG_DIM - K_DIM + 1;
  localparam int N_OUT    = OUT_DIM * OUT_DIM;
  localparam int SUM_W    = 4;
  localparam int IDX_W    = 4;
  localparam int RC_W     = 2;
  localparam int IMG_BITS = IMG_DIM * IMG_DIM;
  localparam int K_BITS   = K_DIM * K_DIM;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  // Pixel (r,c) lives at bit IMG_DIM*r + c of the flattened image.
  function automatic logic [5:0] pix_idx(input logic [2:0] r, input logic [2:0] c);
    return 6'(r) * 6'(IMG_DIM) + 6'(c);
  endfunction

  function automatic logic [3:0] ker_idx(input logic [1:0] i, input logic [1:0] j);
    return 4'(i) * 4'(K_DIM) + 4'(j);
  endfunction

endpackage

// File: rtl/conv3x3_engine_if.sv
// Result stream of the convolution engine: valid/ready handshake with data and raster index.
// The out_bit threshold flag exists only when CONV_THRESH_EN is defined.
interface conv3x3_engine_if;

  logic                       out_valid;
  logic                       out_ready;
  logic [conv_pkg::SUM_W-1:0] out_data;
  logic [conv_pkg::IDX_W-1:0] out_idx;
`ifdef CONV_THRESH_EN
  logic                       out_bit;
`endif

  modport master (
    input  out_ready,
    output out_valid, out_data, out_idx
`ifdef CONV_THRESH_EN
    , out_bit
`endif
  );

  modport slave (
    output out_ready,
    input  out_valid, out_data, out_idx
`ifdef CONV_THRESH_EN
    , out_bit
`endif
  );

endinterface

// File: rtl/conv_window_mac.sv
// Binary 3x3 multiply-accumulate: AND of window and kernel bits, then popcount (0..9).
module conv_window_mac
  import conv_pkg::*;
(
  input  logic [K_BITS-1:0] win,
  input  logic [K_BITS-1:0] ker,
  output logic [SUM_W-1:0]  sum
);

  assign sum = SUM_W'($countones(win & ker));

endmodule

// File: rtl/conv3x3_engine.sv
// Snapshots a 6x6 binary image and 3x3 kernel, then streams 16 window sums in raster order.
// Optional CONV_THRESH_EN adds thresh_in and a registered out_bit = (sum >= threshold).
module conv3x3_engine
  import conv_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IMG_BITS-1:0] img_in,
  input  logic [K_BITS-1:0]   kernel_in,
`ifdef CONV_THRESH_EN
  input  logic [SUM_W-1:0]    thresh_in,
`endif
  output logic                busy,
  output logic                done,
  conv3x3_engine_if.master    out_if
);

  state_t              state_q, state_d;
  logic [IMG_BITS-1:0] img_q;
  logic [K_BITS-1:0]   ker_q;
  logic                capture, load_res, clear_out, accept;
  logic                valid_q;
  logic [SUM_W-1:0]    data_q;
  logic [IDX_W-1:0]    idx_q, win_idx;
  logic [RC_W-1:0]     win_r, win_c;
  logic [K_BITS-1:0]   win;
  logic [SUM_W-1:0]    sum;

  assign accept = valid_q && out_if.out_ready;

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    load_res  = 1'b0;
    clear_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          capture = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD: begin
        load_res = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (accept) begin
          if (idx_q == IDX_W'(N_OUT - 1)) begin
            clear_out = 1'b1;
            state_d   = DONE;
          end else begin
            load_res = 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next window to evaluate: (0,0) when leaving LOAD, otherwise the successor of the shown index.
  assign win_idx = (state_q == LOAD) ? '0 : idx_q + IDX_W'(1);
  assign win_r   = win_idx[IDX_W-1:RC_W];
  assign win_c   = win_idx[RC_W-1:0];

  for (genvar i = 0; i < K_DIM; i++) begin : g_row
    for (genvar j = 0; j < K_DIM; j++) begin : g_col
      assign win[ker_idx(2'(i), 2'(j))] =
        img_q[pix_idx(3'(win_r) + 3'(i), 3'(win_c) + 3'(j))];
    end
  end

  conv_window_mac u_mac (
    .win (win),
    .ker (ker_q),
    .sum (sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      img_q <= '0;
      ker_q <= '0;
    end else if (capture) begin
      img_q <= img_in;
      ker_q <= kernel_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end else if (load_res) begin
      valid_q <= 1'b1;
      data_q  <= sum;
      idx_q   <= win_idx;
    end else if (clear_out) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
    end
  end

`ifdef CONV_THRESH_EN
  logic [SUM_W-1:0] thr_q;
  logic             bit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       thr_q <= '0;
    else if (capture) thr_q <= thresh_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         bit_q <= 1'b0;
    else if (load_res)  bit_q <= (sum >= thr_q);
    else if (clear_out) bit_q <= 1'b0;
  end

  assign out_if.out_bit = bit_q;
`endif

  assign out_if.out_valid = valid_q;
  assign out_if.out_data  = data_q;
  assign out_if.out_idx   = idx_q;
  assign busy             = (state_q != IDLE);
  assign done             = (state_q == DONE);

endmodule

// File: tb/tb_conv3x3_engine.sv
// Scoreboard bench for conv3x3_engine: reference sums queued at start, compared on each handshake.
module tb_conv3x3_engine;
  import conv_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                start;
  logic [IMG_BITS-1:0] img_in;
  logic [K_BITS-1:0]   kernel_in;
  logic                busy, done;
`ifdef CONV_THRESH_EN
  logic [SUM_W-1:0]    thresh_in;
`endif

  conv3x3_engine_if out_if ();

  conv3x3_engine dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .img_in    (img_in),
    .kernel_in (kernel_in),
`ifdef CONV_THRESH_EN
    .thresh_in (thresh_in),
`endif
    .busy      (busy),
    .done      (done),
    .out_if    (out_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int data;
    int bitv;
  } exp_t;

  exp_t sb[$];
  int   checks    = 0;
  int   failures  = 0;
  int   stall_idx = -1;
  int   stall_n   = 0;
  int   stall_cnt = 0;
  logic exp_done  = 1'b0;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  function automatic int ref_sum(input logic [IMG_BITS-1:0] im, input logic [K_BITS-1:0] k,
                                 input int r, input int c);
    int s = 0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        logic [IMG_BITS-1:0] ps;
        logic [K_BITS-1:0]   ks;
        ps = im >> (6 * (r + i) + c + j);
        ks = k >> (3 * i + j);
        if (ps[0] && ks[0]) s++;
      end
    return s;
  endfunction

  // One cycle: decide ready for the coming edge, then score whatever transfers on it.
  task automatic step();
    @(negedge clk);
    if (out_if.out_valid && (int'(out_if.out_idx) == stall_idx) && (stall_cnt < stall_n)) begin
      out_if.out_ready = 1'b0;
      stall_cnt++;
      if (sb.size() > 0) begin
        chk_eq("hold_idx", 32'(out_if.out_idx), 32'(sb[0].idx));
        chk_eq("hold_data", 32'(out_if.out_data), 32'(sb[0].data));
      end
    end else begin
      out_if.out_ready = 1'b1;
      if (!out_if.out_valid || (int'(out_if.out_idx) != stall_idx)) stall_cnt = 0;
    end
    if (!out_if.out_valid) begin
      chk_eq("idle_data", 32'(out_if.out_data), 0);
      chk_eq("idle_idx", 32'(out_if.out_idx), 0);
    end
    chk_eq("done", 32'(done), 32'(exp_done));
    exp_done = 1'b0;
    if (out_if.out_valid && out_if.out_ready) begin
      if (sb.size() == 0) begin
        chk_eq("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk_eq("idx", 32'(out_if.out_idx), 32'(e.idx));
        chk_eq("data", 32'(out_if.out_data), 32'(e.data));
`ifdef CONV_THRESH_EN
        chk_eq("out_bit", 32'(out_if.out_bit), 32'(e.bitv));
`endif
        if (e.idx == N_OUT - 1) exp_done = 1'b1;
      end
    end
    if (!rst_n) exp_done = 1'b0;
  endtask

  task automatic run_frame(input logic [IMG_BITS-1:0] im, input logic [K_BITS-1:0] k,
                           input int thr, input int st_idx, input int st_n,
                           input int inj_idx, input int rst_idx, input int exp_len);
    bit fin = 0;
    bit inj_on = 0;
    step();
    stall_idx = st_idx;
    stall_n   = st_n;
    for (int n = 0; n < N_OUT; n++) begin
      exp_t e;
      e.idx  = n;
      e.data = ref_sum(im, k, n / 4, n % 4);
      e.bitv = (e.data >= thr) ? 1 : 0;
      sb.push_back(e);
    end
    img_in    = im;
    kernel_in = k;
`ifdef CONV_THRESH_EN
    thresh_in = 4'(thr);
`endif
    start = 1'b1;
    for (int n = 1; n <= 300 && !fin; n++) begin
      step();
      if (n == 1) begin
        start = 1'b0;
        chk_eq("lat_busy", 32'(busy), 1);
        chk_eq("lat_valid_early", 32'(out_if.out_valid), 0);
      end
      if (n == 2) begin
        chk_eq("lat_valid", 32'(out_if.out_valid), 1);
        chk_eq("lat_idx0", 32'(out_if.out_idx), 0);
      end
      if (inj_on) begin
        start  = 1'b0;
        inj_on = 0;
      end
      if (out_if.out_valid && int'(out_if.out_idx) == inj_idx && n > 2) begin
        start  = 1'b1;
        img_in = ~im;
        inj_on = 1;
        inj_idx = -1;
      end
      if (rst_idx >= 0 && out_if.out_valid && int'(out_if.out_idx) == rst_idx) begin
        rst_n = 1'b0;
        #1;
        chk_eq("rst_valid", 32'(out_if.out_valid), 0);
        chk_eq("rst_data", 32'(out_if.out_data), 0);
        chk_eq("rst_idx", 32'(out_if.out_idx), 0);
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_done", 32'(done), 0);
        sb.delete();
        repeat (3) step();
        rst_n = 1'b1;
        repeat (3) step();
        chk_eq("post_rst_busy", 32'(busy), 0);
        fin = 1;
      end else if (done) begin
        fin = 1;
        chk_eq("done_busy", 32'(busy), 1);
        if (exp_len >= 0) chk_eq("frame_len", 32'(n), 32'(exp_len));
        chk_eq("sb_empty", 32'(sb.size()), 0);
      end
    end
    if (!fin) chk_eq("frame_timeout", 0, 1);
    start = 1'b0;
    stall_idx = -1;
    stall_n   = 0;
  endtask

  initial begin
    logic [IMG_BITS-1:0] chk_img, ra, rb;
    rst_n     = 1'b0;
    start     = 1'b0;
    img_in    = '0;
    kernel_in = '0;
    out_if.out_ready = 1'b1;
`ifdef CONV_THRESH_EN
    thresh_in = '0;
`endif
    repeat (2) step();
    chk_eq("reset_valid", 32'(out_if.out_valid), 0);
    chk_eq("reset_busy", 32'(busy), 0);
    chk_eq("reset_done", 32'(done), 0);
    rst_n = 1'b1;
    step();

    // all ones, full kernel, free-running consumer
    run_frame({IMG_BITS{1'b1}}, 9'h1FF, 5, -1, 0, -1, -1, 18);

    chk_img = '0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        if ((r + c) % 2 == 0) chk_img = chk_img | (IMG_BITS'(1) << (6 * r + c));
    run_frame(chk_img, 9'h010, 1, -1, 0, -1, -1, 18);

    // consumer stalls idx 5 for three cycles
    run_frame({IMG_BITS{1'b1}}, 9'h1FF, 9, 5, 3, -1, -1, 21);

    ra = {$urandom(), $urandom()};
    rb = {$urandom(), $urandom()};
    run_frame(ra, 9'(~$urandom()), 4, -1, 0, 7, -1, 18);
    run_frame(~ra, 9'h1B5, 3, -1, 0, -1, -1, 18);

    run_frame(rb, 9'h1FF, 5, -1, 0, -1, 9, -1);
    run_frame(rb, 9'h1FF, 5, -1, 0, -1, -1, 18);

    run_frame({IMG_BITS{1'b1}}, 9'h0FF, 5, -1, 0, -1, -1, 18);
    run_frame({IMG_BITS{1'b1}}, 9'h0FF, 9, -1, 0, -1, -1, 18);
    run_frame(ra ^ rb, 9'(~$urandom()), 0, 15, 2, -1, -1, 20);
    run_frame(rb, 9'h0AA, 2, 0, 4, -1, -1, 22);

    step();
    chk_eq("final_busy", 32'(busy), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
